stack_mem_arbiter: RTL and testbench

Arbiter that shares the single-port 16-bit stack memory between the CPU datapath (push/pop traffic from the stack-pointer unit) and a debug/loader port. CPU traffic wins by default. A starvation counter guarantees the debug port forward progress. A registered halt mode lets the loader own the memory exclusively while the CPU is frozen. It sits between `cpu`'s stack port and the stack memory instance.

---
 rtl/stack_mem_arbiter.sv | 99 +++++++++
 tb/tb_stack_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_mem_arbiter.sv
// Shares the single-port stack memory between the CPU stack port and a debug/loader port.
// CPU wins by default; a starvation counter forces a debug grant, and halt mode hands the memory to debug.
module stack_mem_arbiter #(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic              o_cpu_gnt,
   output logic              o_cpu_rvalid,
   output logic [DATA_W-1:0] o_cpu_rdata,
   input  logic              i_dbg_req,
   input  logic              i_dbg_we,
   input  logic [ADDR_W-1:0] i_dbg_addr,
   input  logic [DATA_W-1:0] i_dbg_wdata,
   output logic              o_dbg_gnt,
   output logic              o_dbg_rvalid,
   output logic [DATA_W-1:0] o_dbg_rdata,
   input  logic              i_dbg_halt,
   output logic              o_halted,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic       halted_q;
   logic [3:0] starve_cnt;
   logic       cpu_rvalid_q;
   logic       dbg_rvalid_q;
   logic       cpu_gnt;
   logic       dbg_gnt;

   // Debug wins over a pending CPU request only once it has been denied LIMIT times in a row.
   always_comb begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
      if (halted_q) begin
         dbg_gnt = i_dbg_req;
      end else if (i_cpu_req && !(i_dbg_req && (starve_cnt == LIMIT))) begin
         cpu_gnt = 1'b1;
      end else if (i_dbg_req) begin
         dbg_gnt = 1'b1;
      end
   end

   always_comb begin
      o_mem_en    = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      if (cpu_gnt) begin
         o_mem_en    = 1'b1;
         o_mem_we    = i_cpu_we;
         o_mem_addr  = i_cpu_addr;
         o_mem_wdata = i_cpu_wdata;
      end else if (dbg_gnt) begin
         o_mem_en    = 1'b1;
         o_mem_we    = i_dbg_we;
         o_mem_addr  = i_dbg_addr;
         o_mem_wdata = i_dbg_wdata;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         halted_q     <= 1'b0;
         starve_cnt   <= 4'd0;
         cpu_rvalid_q <= 1'b0;
         dbg_rvalid_q <= 1'b0;
      end else begin
         halted_q     <= i_dbg_halt;
         cpu_rvalid_q <= cpu_gnt & ~i_cpu_we;
         dbg_rvalid_q <= dbg_gnt & ~i_dbg_we;
         if (dbg_gnt || !i_dbg_req) begin
            starve_cnt <= 4'd0;
         end else if (cpu_gnt && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
         end
      end
   end

   assign o_cpu_gnt    = cpu_gnt;
   assign o_dbg_gnt    = dbg_gnt;
   assign o_cpu_rvalid = cpu_rvalid_q;
   assign o_dbg_rvalid = dbg_rvalid_q;
   assign o_cpu_rdata  = i_mem_rdata;
   assign o_dbg_rdata  = i_mem_rdata;
   assign o_halted     = halted_q;

endmodule

// File: tb/tb_stack_mem_arbiter.sv
// Bench for stack_mem_arbiter: directed table, hand-written corner sequences,
// and random traffic compared against a cycle-level reference model.
module tb_stack_mem_arbiter;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam int LIMIT  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cpu_req, cpu_we, dbg_req, dbg_we, dbg_halt;
   logic [ADDR_W-1:0] cpu_addr, dbg_addr;
   logic [DATA_W-1:0] cpu_wdata, dbg_wdata;
   logic              cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, halted;
   logic [DATA_W-1:0] cpu_rdata, dbg_rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   stack_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
      .i_clock(clk), .i_reset_n(rst_n),
      .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
      .o_cpu_gnt(cpu_gnt), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
      .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
      .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata),
      .i_dbg_halt(dbg_halt), .o_halted(halted),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata)
   );

   // Memory contents are stored XORed with a per-address seed, so an all-zero array reads as the preload.
   function automatic logic [DATA_W-1:0] seed(input logic [ADDR_W-1:0] a);
      return {8'h11 + a, a};
   endfunction

   logic [DATA_W-1:0] mem [256] = '{default: 16'h0000};

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata ^ seed(mem_addr);
         else        mem_rdata     <= mem[mem_addr] ^ seed(mem_addr);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
      dbg_halt = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit c_req; bit d_req; bit halt;
      bit e_cpu; bit e_dbg; bit e_halted;
   } vec_t;

   vec_t vecs [16];

   // reference model state
   bit                m_halted;
   int                m_cnt;
   bit                m_cpu_rv, m_dbg_rv;
   logic [DATA_W-1:0] m_rdata;
   logic [DATA_W-1:0] refmem [int];

   initial begin
      bit e_cpu, e_dbg;
      logic [ADDR_W-1:0] ga;

      vecs = '{
         '{1,1,0, 1,0,0}, '{1,1,0, 1,0,0}, '{1,1,0, 1,0,0}, '{1,1,0, 1,0,0},
         '{1,1,0, 0,1,0}, '{1,1,0, 1,0,0}, '{1,1,0, 1,0,0}, '{1,1,0, 1,0,0},
         '{1,1,0, 1,0,0}, '{1,1,0, 0,1,0}, '{0,1,0, 0,1,0}, '{1,0,1, 1,0,0},
         '{1,1,1, 0,1,1}, '{1,0,0, 0,0,1}, '{1,0,0, 1,0,0}, '{1,1,0, 1,0,0}
      };

      rst_n = 1'b0;
      idle_inputs();
      #1;
      chk("rst_cpu_gnt", cpu_gnt, 0);
      chk("rst_dbg_gnt", dbg_gnt, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_halted", halted, 0);
      chk("rst_cpu_rvalid", cpu_rvalid, 0);
      chk("rst_dbg_rvalid", dbg_rvalid, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // CPU read of preloaded address 0
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h00;
      #1;
      chk("rd0_gnt", cpu_gnt, 1);
      chk("rd0_mem_en", mem_en, 1);
      chk("rd0_mem_addr", mem_addr, 8'h00);
      @(negedge clk);
      cpu_req = 0;
      #1;
      chk("rd0_rvalid", cpu_rvalid, 1);
      chk("rd0_rdata", cpu_rdata, 16'h1100);

      // debug write then read back
      @(negedge clk);
      dbg_req = 1; dbg_we = 1; dbg_addr = 8'h03; dbg_wdata = 16'hBEEF;
      #1;
      chk("dbgw_gnt", dbg_gnt, 1);
      chk("dbgw_mem_we", mem_we, 1);
      chk("dbgw_mem_wdata", mem_wdata, 16'hBEEF);
      @(negedge clk);
      dbg_we = 0;
      #1;
      chk("dbgr_gnt", dbg_gnt, 1);
      chk("dbgr_rvalid_early", dbg_rvalid, 0);
      chk("dbgr_cpu_rvalid", cpu_rvalid, 0);
      @(negedge clk);
      dbg_req = 0;
      #1;
      chk("dbgr_rvalid", dbg_rvalid, 1);
      chk("dbgr_rdata", dbg_rdata, 16'hBEEF);
      chk("dbgr_cpu_rvalid2", cpu_rvalid, 0);

      // halt raised in the same cycle as a granted CPU read of 0x01
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h01; dbg_halt = 1;
      #1;
      chk("halt_cpu_gnt0", cpu_gnt, 1);
      chk("halt_halted0", halted, 0);
      @(negedge clk);
      dbg_req = 1; dbg_we = 0; dbg_addr = 8'h03;
      #1;
      chk("halt_cpu_rvalid", cpu_rvalid, 1);
      chk("halt_cpu_rdata", cpu_rdata, 16'h1201);
      chk("halt_halted1", halted, 1);
      chk("halt_cpu_gnt1", cpu_gnt, 0);
      chk("halt_dbg_gnt1", dbg_gnt, 1);
      @(negedge clk);
      dbg_req = 0; dbg_halt = 0;
      #1;
      chk("halt_halted2", halted, 1);
      chk("halt_cpu_gnt2", cpu_gnt, 0);
      chk("halt_dbg_rvalid", dbg_rvalid, 1);
      chk("halt_dbg_rdata", dbg_rdata, 16'hBEEF);
      @(negedge clk);
      #1;
      chk("halt_exit_halted", halted, 0);
      chk("halt_exit_cpu_gnt", cpu_gnt, 1);
      @(negedge clk);
      cpu_req = 0;

      // starvation pattern and halt handling, one vector per cycle
      do_reset();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         cpu_req = vecs[i].c_req; dbg_req = vecs[i].d_req; dbg_halt = vecs[i].halt;
         cpu_we = 0; dbg_we = 0; cpu_addr = 8'h00; dbg_addr = 8'h00;
         #1;
         chk($sformatf("vec%0d_cpu_gnt", i), cpu_gnt, vecs[i].e_cpu);
         chk($sformatf("vec%0d_dbg_gnt", i), dbg_gnt, vecs[i].e_dbg);
         chk($sformatf("vec%0d_halted", i), halted, vecs[i].e_halted);
      end

      // asynchronous reset between clock edges, right after a granted read
      do_reset();
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h02; dbg_halt = 1;
      @(negedge clk);
      cpu_req = 0;
      #1;
      chk("arst_pre_rvalid", cpu_rvalid, 1);
      chk("arst_pre_halted", halted, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_rvalid", cpu_rvalid, 0);
      chk("arst_halted", halted, 0);
      chk("arst_mem_en", mem_en, 0);
      dbg_halt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("arst_post_rvalid", cpu_rvalid, 0);
         chk("arst_post_halted", halted, 0);
         chk("arst_post_mem_en", mem_en, 0);
      end

      // random traffic against the reference model (addresses kept clear of the directed ones)
      do_reset();
      m_halted = 0; m_cnt = 0; m_cpu_rv = 0; m_dbg_rv = 0; m_rdata = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         cpu_req   = ($urandom_range(0, 9) < 6);
         cpu_we    = $urandom_range(0, 1);
         cpu_addr  = 8'($urandom_range(8'h40, 8'hFF));
         cpu_wdata = 16'($urandom);
         dbg_req   = ($urandom_range(0, 9) < 5);
         dbg_we    = $urandom_range(0, 1);
         dbg_addr  = 8'($urandom_range(8'h40, 8'hFF));
         dbg_wdata = 16'($urandom);
         if ($urandom_range(0, 11) == 0) dbg_halt = ~dbg_halt;
         #1;
         e_cpu = 0; e_dbg = 0;
         if (m_halted)                                 e_dbg = dbg_req;
         else if (cpu_req && !(dbg_req && m_cnt == LIMIT)) e_cpu = 1;
         else if (dbg_req)                             e_dbg = 1;
         chk("rnd_cpu_gnt", cpu_gnt, e_cpu);
         chk("rnd_dbg_gnt", dbg_gnt, e_dbg);
         chk("rnd_halted", halted, m_halted);
         chk("rnd_mem_en", mem_en, e_cpu | e_dbg);
         chk("rnd_mem_we", mem_we, e_cpu ? cpu_we : (e_dbg ? dbg_we : 1'b0));
         chk("rnd_mem_addr", mem_addr, e_cpu ? cpu_addr : (e_dbg ? dbg_addr : 8'h00));
         chk("rnd_mem_wdata", mem_wdata, e_cpu ? cpu_wdata : (e_dbg ? dbg_wdata : 16'h0000));
         chk("rnd_cpu_rvalid", cpu_rvalid, m_cpu_rv);
         chk("rnd_dbg_rvalid", dbg_rvalid, m_dbg_rv);
         if (m_cpu_rv) chk("rnd_cpu_rdata", cpu_rdata, m_rdata);
         if (m_dbg_rv) chk("rnd_dbg_rdata", dbg_rdata, m_rdata);

         // advance the model to the next cycle
         m_cpu_rv = e_cpu && !cpu_we;
         m_dbg_rv = e_dbg && !dbg_we;
         if (e_cpu || e_dbg) begin
            ga = e_cpu ? cpu_addr : dbg_addr;
            if ((e_cpu && cpu_we) || (e_dbg && dbg_we))
               refmem[int'(ga)] = e_cpu ? cpu_wdata : dbg_wdata;
            else
               m_rdata = refmem.exists(int'(ga)) ? refmem[int'(ga)] : seed(ga);
         end
         if (e_dbg || !dbg_req)        m_cnt = 0;
         else if (e_cpu && m_cnt < LIMIT) m_cnt = m_cnt + 1;
         m_halted = dbg_halt;
      end

      @(negedge clk);
      idle_inputs();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
